uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/flex_counter.sv | 44 ++++
 rtl/uart_rx_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and defaults for the UART receiver.
// Imported by uart_rx_ctrl and its bench-facing parameters.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    STOP,
    LOAD
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 10;
  localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: up-counter that wraps rollover_val -> 1, flag registered.
// A clear restarts the count; with count_enable high it lands on 1.
module flex_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            count_enable,
  input  logic [SIZE-1:0] rollover_val,
  output logic [SIZE-1:0] count_out,
  output logic            rollover_flag
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [SIZE-1:0] r_count;
  logic [SIZE-1:0] w_next;
  logic            r_flag;

  always_comb begin
    w_next = r_count;
    if (clear) begin
      w_next = count_enable ? ONE : '0;
    end else if (count_enable) begin
      w_next = (r_count == rollover_val) ? ONE
                                         : r_count + ONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_flag  <= (w_next == rollover_val);
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver with framing and overrun reporting.
// Mid-bit sampling is timed by a cycle counter and a bit counter.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam logic [9:0] CPB_V  = 10'(CLKS_PER_BIT);
  localparam logic [9:0] HALF_V = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] LAST_V = 10'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BITS_V = 4'(DATA_BITS);

  rx_state_t r_state;
  rx_state_t w_next;

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rdy;
  logic                 r_ferr;
  logic                 r_ovr;

  logic       w_edge;
  logic       w_start;
  logic       w_half;
  logic       w_start_ok;
  logic       w_cyc_clr;
  logic       w_cyc_en;
  logic       w_shift;
  logic       w_load_ok;
  logic       w_load_bad;
  logic [9:0] w_cyc_cnt;
  logic       w_cyc_flag;
  logic [3:0] w_bit_cnt;
  logic       w_bit_flag;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge     = r_prev & ~r_sync2;
  assign w_start    = (r_state == IDLE) & w_edge;
  assign w_half     = (r_state == START_CHK) &
                      (w_cyc_cnt == HALF_V);
  assign w_start_ok = w_half & ~r_sync2;

  // Restart on a good start bit so flags land mid-bit afterwards
  assign w_cyc_clr  = w_start | w_start_ok;
  assign w_cyc_en   = (r_state != IDLE);
  assign w_shift    = (r_state == DATA) & w_cyc_flag &
                      (w_bit_cnt != BITS_V);
  assign w_load_ok  = (r_state == LOAD) & w_cyc_flag &
                      r_sync2;
  assign w_load_bad = (r_state == LOAD) & w_cyc_flag &
                      ~r_sync2;

  flex_counter #(.SIZE(10)) u_cyc_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_cyc_clr),
    .count_enable (w_cyc_en),
    .rollover_val (CPB_V),
    .count_out    (w_cyc_cnt),
    .rollover_flag(w_cyc_flag)
  );

  flex_counter #(.SIZE(4)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_start),
    .count_enable (w_shift),
    .rollover_val (BITS_V),
    .count_out    (w_bit_cnt),
    .rollover_flag(w_bit_flag)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_next = START_CHK;
      end
      START_CHK: begin
        if (w_half) w_next = r_sync2 ? IDLE : DATA;
      end
      DATA: begin
        if (w_bit_flag) w_next = STOP;
      end
      // Enter LOAD so the stop bit is judged on the flag cycle
      STOP: begin
        if (w_cyc_cnt == LAST_V) w_next = LOAD;
      end
      LOAD: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_shift) begin
        r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
      end
      if (w_start_ok) begin
        r_ferr <= 1'b0;
      end else if (w_load_bad) begin
        r_ferr <= 1'b1;
      end
      // A read in the load cycle consumes the old frame
      if (w_load_ok) begin
        r_data <= r_shift;
        r_rdy  <= 1'b1;
        r_ovr  <= ~data_read & (r_ovr | r_rdy);
      end else if (data_read) begin
        r_rdy <= 1'b0;
        r_ovr <= 1'b0;
      end
    end
  end

  assign rx_data       = r_data;
  assign data_ready    = r_rdy;
  assign framing_error = r_ferr;
  assign overrun_error = r_ovr;
  assign busy          = (r_state != IDLE);

endmodule
